// File: rtl/ibex_l2_rf_pkg.sv
// Purpose: shared types and constants for the L2 backup register file and its transfer controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Configuration macro: IBEX_L2_RF_RVE_EN
//   defined   -> RV32E, only x1..x15 are transferred (L2RfLastReg = 15)
//   undefined -> RV32I, x1..x31 are transferred     (L2RfLastReg = 31)
package ibex_l2_rf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAVE      = 2'd1,
        RST_ISSUE = 2'd2,
        RST_DRAIN = 2'd3
    } xfer_state_e;

`ifdef IBEX_L2_RF_RVE_EN
    localparam logic [4:0] L2RfLastReg = 5'd15;
`else
    localparam logic [4:0] L2RfLastReg = 5'd31;
`endif

endpackage

// File: rtl/ibex_l2_rf_xfer_ctrl.sv
// Purpose: bulk copy of x1..xLAST between the main register file and the L2 backup file (SAVE / RESTORE).
// Latency: SAVE takes LAST busy cycles, RESTORE takes LAST+1 (one extra for the registered L2 read); done_o follows.
// Backpressure: none; the core stalls while busy_o=1 and requests arriving while busy are dropped.
//
// Configuration macro: IBEX_L2_RF_RVE_EN (see ibex_l2_rf_pkg) selects RV32E (x1..x15) instead of RV32I.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   save_req_i, restore_req_i     start requests, only looked at in IDLE
//   busy_o, done_o, err_o         status; done_o / err_o are one-cycle pulses
//   mrf_raddr_o / mrf_rdata_i     main RF combinational read port
//   mrf_waddr_o/_wdata_o/_we_o    main RF write port
//   l2_addr_o/_wdata_o/_we_o      L2 shared address and write port
//   l2_rdata_i                    L2 read data, valid one cycle after l2_addr_o
module ibex_l2_rf_xfer_ctrl
    import ibex_l2_rf_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 save_req_i,
    input  logic                 restore_req_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [4:0]           mrf_raddr_o,
    input  logic [DataWidth-1:0] mrf_rdata_i,
    output logic [4:0]           mrf_waddr_o,
    output logic [DataWidth-1:0] mrf_wdata_o,
    output logic                 mrf_we_o,
    output logic [4:0]           l2_addr_o,
    output logic [DataWidth-1:0] l2_wdata_o,
    output logic                 l2_we_o,
    input  logic [DataWidth-1:0] l2_rdata_i
);

    xfer_state_e state_q;
    logic [4:0]  cnt_q;
    // Address issued to L2 last cycle; its read data arrives now and is written to the main RF.
    logic [4:0]  cnt_dly_q;
    logic        dly_vld_q;
    logic        done_q;
    logic        err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            cnt_dly_q <= 5'd0;
            dly_vld_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_dly_q <= cnt_q;
            dly_vld_q <= (state_q == RST_ISSUE);
            case (state_q)
                IDLE: begin
                    if (save_req_i && restore_req_i) begin
                        err_q <= 1'b1;
                    end else if (save_req_i) begin
                        state_q <= SAVE;
                        cnt_q   <= 5'd1;
                    end else if (restore_req_i) begin
                        state_q <= RST_ISSUE;
                        cnt_q   <= 5'd1;
                    end
                end
                SAVE: begin
                    if (cnt_q == L2RfLastReg) begin
                        state_q <= IDLE;
                        cnt_q   <= 5'd0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                RST_ISSUE: begin
                    if (cnt_q == L2RfLastReg) begin
                        state_q <= RST_DRAIN;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                RST_DRAIN: begin
                    // The write of LAST happens in this cycle from the delay register.
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Every output is a plain decode of registered state, gated so nothing leaks out in IDLE.
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

    assign mrf_raddr_o = (state_q == SAVE) ? cnt_q : 5'd0;
    assign l2_addr_o   = ((state_q == SAVE) || (state_q == RST_ISSUE)) ? cnt_q : 5'd0;
    assign l2_we_o     = (state_q == SAVE);
    assign l2_wdata_o  = (state_q == SAVE) ? mrf_rdata_i : '0;

    assign mrf_we_o    = dly_vld_q;
    assign mrf_waddr_o = dly_vld_q ? cnt_dly_q : 5'd0;
    assign mrf_wdata_o = dly_vld_q ? l2_rdata_i : '0;

endmodule

// File: tb/tb_ibex_l2_rf_xfer_ctrl.sv
// Purpose: randomized scoreboard bench for ibex_l2_rf_xfer_ctrl with behavioural main/L2 register files.
// Latency: n/a.
// Backpressure: n/a.
module tb_ibex_l2_rf_xfer_ctrl;
    import ibex_l2_rf_pkg::*;

    localparam int LAST = int'(L2RfLastReg);

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        save_req_i = 1'b0;
    logic        restore_req_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [4:0]  mrf_raddr_o, mrf_waddr_o, l2_addr_o;
    logic [31:0] mrf_rdata_i, mrf_wdata_o, l2_wdata_o;
    logic [31:0] l2_rdata_i = 32'd0;
    logic        mrf_we_o, l2_we_o;

    always #5 clk = ~clk;

    ibex_l2_rf_xfer_ctrl #(.DataWidth(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .save_req_i    (save_req_i),
        .restore_req_i (restore_req_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .mrf_raddr_o   (mrf_raddr_o),
        .mrf_rdata_i   (mrf_rdata_i),
        .mrf_waddr_o   (mrf_waddr_o),
        .mrf_wdata_o   (mrf_wdata_o),
        .mrf_we_o      (mrf_we_o),
        .l2_addr_o     (l2_addr_o),
        .l2_wdata_o    (l2_wdata_o),
        .l2_we_o       (l2_we_o),
        .l2_rdata_i    (l2_rdata_i)
    );

    // Behavioural register files attached to the DUT.
    logic [31:0] mrf [32];
    logic [31:0] l2  [32];
    assign mrf_rdata_i = mrf[mrf_raddr_o];
    always @(posedge clk) begin
        if (mrf_we_o) mrf[mrf_waddr_o] <= mrf_wdata_o;
        if (l2_we_o)  l2[l2_addr_o]    <= l2_wdata_o;
        l2_rdata_i <= l2[l2_addr_o];
    end

    // Reference contents of both files after every completed operation.
    logic [31:0] exp_mrf [32];
    logic [31:0] exp_l2  [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t q_l2[$];
    wr_t q_mrf[$];
    int  q_ev[$];   // 0 = err pulse, >0 = done pulse with that many busy cycles before it

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a status pulse.
    int         busy_cnt = 0;
    logic [4:0] prev_l2_addr = 5'd0;
    initial begin
        wr_t e;
        int  ev;
        forever begin
            @(negedge clk);
            if (l2_we_o) begin
                if (q_l2.size() == 0) chk("l2_write_unexpected", {27'd0, l2_addr_o}, 32'hFFFF_FFFF);
                else begin
                    e = q_l2.pop_front();
                    chk("l2_waddr", {27'd0, l2_addr_o}, {27'd0, e.a});
                    chk("l2_wdata", l2_wdata_o, e.d);
                end
            end
            if (mrf_we_o) begin
                if (q_mrf.size() == 0) chk("mrf_write_unexpected", {27'd0, mrf_waddr_o}, 32'hFFFF_FFFF);
                else begin
                    e = q_mrf.pop_front();
                    chk("mrf_waddr", {27'd0, mrf_waddr_o}, {27'd0, e.a});
                    chk("mrf_wdata", mrf_wdata_o, e.d);
                    chk("mrf_waddr_lags_l2_addr", {27'd0, mrf_waddr_o}, {27'd0, prev_l2_addr});
                end
            end
            if (mrf_we_o || l2_we_o) begin
                chk("both_we", {31'd0, mrf_we_o & l2_we_o}, 32'd0);
                chk("we_while_idle", {31'd0, busy_o}, 32'd1);
            end
            if (done_o || err_o) begin
                chk("done_and_err", {31'd0, done_o & err_o}, 32'd0);
                if (q_ev.size() == 0) chk("status_pulse_unexpected", {30'd0, done_o, err_o}, 32'd0);
                else begin
                    ev = q_ev.pop_front();
                    chk("pulse_kind_done", {31'd0, done_o}, (ev > 0) ? 32'd1 : 32'd0);
                    if (ev > 0) chk("busy_cycles", busy_cnt, ev);
                end
            end
            if (busy_o) busy_cnt++;
            else busy_cnt = 0;
            prev_l2_addr = l2_addr_o;
        end
    end

    task automatic pulse(input logic s, input logic r);
        @(negedge clk);
        save_req_i    = s;
        restore_req_i = r;
        @(negedge clk);
        save_req_i    = 1'b0;
        restore_req_i = 1'b0;
    endtask

    task automatic expect_save();
        for (int i = 1; i <= LAST; i++) begin
            q_l2.push_back('{a: 5'(i), d: exp_mrf[i]});
            exp_l2[i] = exp_mrf[i];
        end
        q_ev.push_back(LAST);
    endtask

    task automatic expect_restore();
        for (int i = 1; i <= LAST; i++) begin
            q_mrf.push_back('{a: 5'(i), d: exp_l2[i]});
            exp_mrf[i] = exp_l2[i];
        end
        q_ev.push_back(LAST + 1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (!busy_o && q_ev.size() == 0 && q_l2.size() == 0 && q_mrf.size() == 0) break;
        end
        chk("wait_idle_timeout", (k < 200) ? 32'd0 : 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_files(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_l2"}, l2[i], exp_l2[i]);
            chk({tag, "_mrf"}, mrf[i], exp_mrf[i]);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_we"}, {30'd0, mrf_we_o, l2_we_o}, 32'd0);
        chk({tag, "_addr"}, {17'd0, mrf_raddr_o, mrf_waddr_o, l2_addr_o}, 32'd0);
        chk({tag, "_wdata_mrf"}, mrf_wdata_o, 32'd0);
        chk({tag, "_wdata_l2"}, l2_wdata_o, 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32; i++) begin
            mrf[i] = 32'hA5A5_0000 + 32'(i);
            l2[i]  = 32'hDEAD_0000 + 32'(i);
        end
        mrf[0] = 32'd0;
        l2[0]  = 32'd0;
        for (int i = 0; i < 32; i++) begin
            exp_mrf[i] = mrf[i];
            exp_l2[i]  = l2[i];
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_i = 1'b0;

        // SAVE of the A5A5 pattern.
        expect_save();
        pulse(1'b1, 1'b0);
        wait_idle();
        cmp_files("save");

        // RESTORE of the 1234 pattern.
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            l2[i]     = 32'h1234_0000 + 32'(i);
            exp_l2[i] = l2[i];
        end
        expect_restore();
        pulse(1'b0, 1'b1);
        wait_idle();
        cmp_files("restore");

        // Simultaneous requests: error pulse only.
        q_ev.push_back(0);
        pulse(1'b1, 1'b1);
        chk("err_busy", {31'd0, busy_o}, 32'd0);
        wait_idle();
        cmp_files("err");

        // RESTORE request in the middle of a SAVE is dropped.
        expect_save();
        pulse(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        restore_req_i = 1'b1;
        @(negedge clk);
        restore_req_i = 1'b0;
        wait_idle();
        cmp_files("save_ignore_restore");

        // Reset while SAVE sits at x10.
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            mrf[i]     = 32'h5A00_0000 + 32'(i);
            exp_mrf[i] = mrf[i];
        end
        for (int i = 1; i <= 10; i++) q_l2.push_back('{a: 5'(i), d: exp_mrf[i]});
        pulse(1'b1, 1'b0);
        for (k = 0; k < 40; k++) begin
            if (mrf_raddr_o == 5'd10) break;
            @(negedge clk);
        end
        chk("reach_x10_timeout", (k < 40) ? 32'd0 : 32'd1, 32'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("midsave_reset");
        @(negedge clk);
        rst_i = 1'b0;
        q_l2.delete();
        // x1..x10 were handed to the L2 file (x10 in the reset cycle itself); the rest keep old data.
        for (int i = 1; i <= 10; i++) exp_l2[i] = exp_mrf[i];
        repeat (6) @(negedge clk);
        cmp_files("midsave_reset");

        // Randomized mix of operations.
        for (int it = 0; it < 10; it++) begin
            int op;
            op = $urandom_range(0, 2);
            @(negedge clk);
            for (int i = 1; i < 32; i++) begin
                mrf[i] = $urandom;
                l2[i]  = $urandom;
                exp_mrf[i] = mrf[i];
                exp_l2[i]  = l2[i];
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (op == 0) begin
                expect_save();
                pulse(1'b1, 1'b0);
            end else if (op == 1) begin
                expect_restore();
                pulse(1'b0, 1'b1);
            end else begin
                q_ev.push_back(0);
                pulse(1'b1, 1'b1);
            end
            wait_idle();
            cmp_files("random");
        end

        chk("leftover_events", q_ev.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
